// File: rtl/op_sequencer.sv
// One-press stage-strobe sequencer for the register-file/ALU lab datapath.
// Debounces btn_go and emits clk_RR, clk_F, clk_WB as non-overlapping strobes.
module op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int GAP_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_go,
  input  logic       wb_en,
  output logic       clk_RR,
  output logic       clk_F,
  output logic       clk_WB,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_count
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] G_LAST  = PW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RR_HI, RR_GAP, F_HI, F_GAP, WB_HI, WB_GAP, DONE
  } state_e;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          acc_q, acc_d;
  logic          start_q, start_d;
  state_e        state_q, state_d;
  logic [PW-1:0] ph_cnt_q, ph_cnt_d;
  logic          wb_q, wb_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rr_q, f_q, wbs_q, busy_q, done_q;
  logic          p_end, g_end;

  always_comb begin
    db_cnt_d = '0;
    acc_d    = acc_q;
    start_d  = 1'b0;
    if (sync2_q != acc_q) begin
      if (db_cnt_q == DB_LAST) begin
        acc_d   = sync2_q;
        start_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  assign p_end = (ph_cnt_q == P_LAST);
  assign g_end = (ph_cnt_q == G_LAST);

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q + PW'(1);
    wb_d     = wb_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        ph_cnt_d = '0;
        if (start_q) begin
          state_d = RR_HI;
          wb_d    = wb_en;
        end
      end
      RR_HI:  if (p_end) state_d = RR_GAP;
      RR_GAP: if (g_end) state_d = F_HI;
      F_HI:   if (p_end) state_d = F_GAP;
      F_GAP:  if (g_end) state_d = wb_q ? WB_HI : DONE;
      WB_HI:  if (p_end) state_d = WB_GAP;
      WB_GAP: if (g_end) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // every state change restarts the phase counter
    if (state_d != state_q) ph_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      acc_q    <= 1'b0;
      start_q  <= 1'b0;
      state_q  <= IDLE;
      ph_cnt_q <= '0;
      wb_q     <= 1'b0;
      cnt_q    <= 8'd0;
      rr_q     <= 1'b0;
      f_q      <= 1'b0;
      wbs_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_go;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      acc_q    <= acc_d;
      start_q  <= start_d;
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      wb_q     <= wb_d;
      cnt_q    <= cnt_d;
      rr_q     <= (state_d == RR_HI);
      f_q      <= (state_d == F_HI);
      wbs_q    <= (state_d == WB_HI);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign clk_RR   = rr_q;
  assign clk_F    = f_q;
  assign clk_WB   = wbs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign op_count = cnt_q;

endmodule
